pi_accum: RTL and testbench
===========================

// Module: pi_accum
// PURPOSE
//  Consumes the per-point inside/outside verdicts from the coordinate stage
//  (x^2+y^2 < 1 test) and accumulates one Monte-Carlo batch of 2^SAMPLE_LOG2
//  points. Each batch result is presented as a fixed-point pi estimate on a
//  valid/ready handshake. Sits directly downstream of the coordinate stage;
//  feeds the host/UART reporting logic.
// PARAMETERS
//  SAMPLE_LOG2  20  log2 of points per batch; legal range 2..30
//  AUTO_RESTART 0   1: after result accepted, start next batch without start
// PORTS
//  clk           in   1              system clock, rising edge
//  rst_n         in   1              asynchronous reset, active-low
//  start         in   1              1-cycle pulse: begin a batch (IDLE only)
//  coord_valid   in   1              1-cycle strobe: op_lt_1 is valid
//  op_lt_1       in   1              1 = point fell inside the unit circle
//  busy          out  1              1 while in RUN
//  result_valid  out  1              pi_est/hit_count held and valid
//  result_ready  in   1              consumer accepts result
//  hit_count     out  SAMPLE_LOG2+1  inside-circle count for the batch
//  pi_est        out  SAMPLE_LOG2+1  pi estimate, unsigned Q3.(SAMPLE_LOG2-2)
//  dropped       out  1              sticky: a coord_valid arrived outside RUN
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy, result_valid, dropped=0;
//    hit_count, pi_est=0; internal samp_cnt, hit_cnt=0.
//  - States: IDLE, RUN, DONE (2-bit encoding from package).
//  - IDLE: start=1 -> RUN next cycle; samp_cnt and hit_cnt cleared to 0.
//  - RUN: on each coord_valid, samp_cnt += 1; hit_cnt += op_lt_1.
//    When coord_valid && samp_cnt == 2^SAMPLE_LOG2-1 (last point), the
//    batch completes: hit_count <= hit_cnt + op_lt_1 (final point counted),
//    result_valid <= 1, state -> DONE. Latency: result_valid rises 1 cycle
//    after the final coord_valid.
//  - pi_est = 4*hits/2^SAMPLE_LOG2 = hit_count itself reinterpreted as
//    Q3.(SAMPLE_LOG2-2); no arithmetic, same register. All-inside batch
//    gives hit_count = 2^SAMPLE_LOG2 (= 4.0); width SAMPLE_LOG2+1 covers it.
//  - samp_cnt is SAMPLE_LOG2 bits and wraps to 0 exactly at batch end.
//  - DONE: hit_count/pi_est/result_valid held stable until
//    result_valid && result_ready; that cycle result_valid <= 0 and state
//    -> IDLE (AUTO_RESTART=0) or -> RUN with counters cleared (=1).
//    result_ready may be high on the same cycle result_valid rises; the
//    handshake still needs result_valid=1 sampled, so min DONE dwell is 1.
//  - start is ignored in RUN and DONE (no restart, no error).
//  - coord_valid in IDLE or DONE: sample discarded, dropped <= 1 (sticky,
//    cleared only by reset). Includes the DONE->RUN cycle with AUTO_RESTART.
//  - busy = (state == RUN), registered.
//  - Reset asserted mid-batch: all state lost, outputs to reset values at
//    once; no partial result is emitted.
// STRUCTURE
//  - pi_pkg: state encoding (ST_IDLE=0, ST_RUN=1, ST_DONE=2), Q-format
//    helper constant PI_FRAC = SAMPLE_LOG2-2.
//  - One sub-module: pi_batch_ctr (samp_cnt + hit_cnt with clear/enable,
//    flags last-sample). FSM, result registers and handshake in top.
// TESTING (SAMPLE_LOG2=4, batch = 16)
//  1 Reset: rst_n low mid-RUN -> busy, result_valid, hit_count, dropped = 0
//    immediately, without a clock edge.
//  2 start, 16 coord_valid with op_lt_1 = 1 on 13 -> result_valid 1 cycle
//    after 16th; hit_count=13; pi_est=0b01101 = 3.25.
//  3 All 16 inside -> hit_count=16 (4.0); all outside -> hit_count=0.
//  4 result_ready held low 10 cycles -> outputs stable; then ready=1 ->
//    result_valid drops next cycle; state IDLE; start during DONE ignored.
//  5 coord_valid while IDLE -> dropped=1, hit_count unchanged; start
//    pulsed during RUN -> count not reset.
//  6 AUTO_RESTART=1, back-to-back 16-point bursts with ready tied high ->
//    consecutive results 13 then 7, busy re-asserts without start.

Source files
------------

// File: rtl/pi_pkg.sv
// Package for the pi_accum Monte-Carlo batch accumulator.
// Holds the FSM state encoding and the Q-format helpers for the pi estimate.
package pi_pkg;

  // FSM state encoding shared by the accumulator.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pi_state_e;

  // Default batch size and its fixed-point fraction width.
  localparam int unsigned SAMPLE_LOG2_DEFAULT = 20;
  localparam int unsigned PI_FRAC = SAMPLE_LOG2_DEFAULT - 2;

  // Fraction bits of the pi estimate for an arbitrary batch size: the estimate is
  // 4*hits/2^n, i.e. hits read as Q3.(n-2).
  function automatic int unsigned pi_frac(input int unsigned sample_log2);
    return sample_log2 - 2;
  endfunction

endpackage

// File: rtl/pi_batch_ctr.sv
// Batch counters for pi_accum.
// Counts accepted samples and inside-circle hits for one batch, and flags when
// the sample counter is sitting on the final point of the batch.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous reset, active-low
//   clr       in   clear both counters (wins over en)
//   en        in   count one sample this cycle
//   hit       in   the sample being counted fell inside the circle
//   hit_cnt   out  hits accumulated so far (SAMPLE_LOG2+1 bits)
//   last      out  samp_cnt == 2^SAMPLE_LOG2-1, next sample ends the batch
module pi_batch_ctr #(
  parameter int unsigned SAMPLE_LOG2 = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   hit,
  output logic [SAMPLE_LOG2:0]   hit_cnt,
  output logic                   last
);

  logic [SAMPLE_LOG2-1:0] samp_cnt_q;
  logic [SAMPLE_LOG2:0]   hit_cnt_q;

  // samp_cnt is exactly SAMPLE_LOG2 wide so it wraps to 0 on the last point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_q <= '0;
      hit_cnt_q  <= '0;
    end else if (clr) begin
      samp_cnt_q <= '0;
      hit_cnt_q  <= '0;
    end else if (en) begin
      samp_cnt_q <= samp_cnt_q + 1'b1;
      hit_cnt_q  <= hit_cnt_q + (SAMPLE_LOG2 + 1)'(hit);
    end
  end

  always_comb begin
    hit_cnt = hit_cnt_q;
    last    = (samp_cnt_q == {SAMPLE_LOG2{1'b1}});
  end

endmodule

// File: rtl/pi_accum.sv
// Monte-Carlo pi accumulator.
// Consumes per-point inside/outside verdicts from the coordinate stage,
// accumulates a batch of 2^SAMPLE_LOG2 points and presents the hit count as a
// fixed-point pi estimate on a valid/ready handshake.
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous reset, active-low
//   start         in   pulse: begin a batch (honoured in IDLE only)
//   coord_valid   in   strobe: op_lt_1 is valid
//   op_lt_1       in   1 = point fell inside the unit circle
//   busy          out  registered, 1 while in RUN
//   result_valid  out  hit_count/pi_est valid and held
//   result_ready  in   consumer accepts result
//   hit_count     out  inside-circle count for the batch
//   pi_est        out  pi estimate, unsigned Q3.(SAMPLE_LOG2-2)
//   dropped       out  sticky: a coord_valid arrived outside RUN
module pi_accum
  import pi_pkg::*;
#(
  parameter int unsigned SAMPLE_LOG2  = 20,
  parameter bit          AUTO_RESTART = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 coord_valid,
  input  logic                 op_lt_1,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [SAMPLE_LOG2:0] hit_count,
  output logic [SAMPLE_LOG2:0] pi_est,
  output logic                 dropped
);

  if (SAMPLE_LOG2 < 2 || SAMPLE_LOG2 > 30) begin : g_bad_param
    $error("pi_accum: SAMPLE_LOG2 must be in 2..30");
  end

  pi_state_e            state_q;
  logic [SAMPLE_LOG2:0] hit_cnt;
  logic                 last;
  logic                 ctr_clr;
  logic                 ctr_en;
  logic                 batch_end;
  logic                 handshake;

  always_comb begin
    handshake = (state_q == ST_DONE) && result_valid && result_ready;
    ctr_en    = (state_q == ST_RUN) && coord_valid;
    batch_end = ctr_en && last;
    // Counters restart on a fresh start, or on acceptance when auto-restarting.
    ctr_clr   = ((state_q == ST_IDLE) && start) || (handshake && AUTO_RESTART);
  end

  pi_batch_ctr #(
    .SAMPLE_LOG2(SAMPLE_LOG2)
  ) u_batch_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .hit    (op_lt_1),
    .hit_cnt(hit_cnt),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      hit_count    <= '0;
      dropped      <= 1'b0;
    end else begin
      // Samples outside RUN are discarded but remembered.
      if (coord_valid && (state_q != ST_RUN)) begin
        dropped <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (batch_end) begin
            // Final point is not yet in hit_cnt, so fold it in here.
            hit_count    <= hit_cnt + (SAMPLE_LOG2 + 1)'(op_lt_1);
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (handshake) begin
            result_valid <= 1'b0;
            if (AUTO_RESTART) begin
              state_q <= ST_RUN;
              busy    <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // 4*hits/2^n is the hit count itself read as Q3.(n-2).
  assign pi_est = hit_count;

endmodule

// File: tb/tb_pi_accum.sv
module tb_pi_accum;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start_a = 0, cv_a = 0, op_a = 0, ready_a = 0;
  logic busy_a, rv_a, dropped_a;
  logic [N:0] hit_a, pi_a;

  logic start_b = 0, cv_b = 0, op_b = 0;
  logic ready_b = 1'b1;
  logic busy_b, rv_b, dropped_b;
  logic [N:0] hit_b, pi_b;

  int checks = 0;
  int errors = 0;

  logic [N:0] exp_a[$];
  logic [N:0] exp_b[$];

  always #5 clk = ~clk;

  pi_accum #(.SAMPLE_LOG2(N), .AUTO_RESTART(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .coord_valid(cv_a), .op_lt_1(op_a),
    .busy(busy_a), .result_valid(rv_a), .result_ready(ready_a), .hit_count(hit_a),
    .pi_est(pi_a), .dropped(dropped_a)
  );

  pi_accum #(.SAMPLE_LOG2(N), .AUTO_RESTART(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .coord_valid(cv_b), .op_lt_1(op_b),
    .busy(busy_b), .result_valid(rv_b), .result_ready(ready_b), .hit_count(hit_b),
    .pi_est(pi_b), .dropped(dropped_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a new result is presented when result_valid rises.
  logic prev_rv_a = 1'b0;
  logic prev_rv_b = 1'b0;

  always @(negedge clk) begin
    if (rv_a && !prev_rv_a) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_result", 32'(rv_a), 32'd0);
      end else begin
        logic [N:0] e;
        e = exp_a.pop_front();
        check("a_hit_count", 32'(hit_a), 32'(e));
        check("a_pi_est", 32'(pi_a), 32'(e));
      end
    end
    if (rv_b && !prev_rv_b) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_result", 32'(rv_b), 32'd0);
      end else begin
        logic [N:0] e;
        e = exp_b.pop_front();
        check("b_hit_count", 32'(hit_b), 32'(e));
        check("b_pi_est", 32'(pi_b), 32'(e));
      end
    end
    prev_rv_a = rv_a;
    prev_rv_b = rv_b;
  end

  // Drive 16 points, MSB of pat first; optionally pulse start mid-batch.
  task automatic send_batch(input bit use_b, input logic [15:0] pat, input bit start_mid);
    for (int i = 0; i < 16; i++) begin
      step();
      if (use_b) begin
        cv_b = 1'b1;
        op_b = pat[15-i];
      end else begin
        cv_a    = 1'b1;
        op_a    = pat[15-i];
        start_a = start_mid && (i == 5);
      end
      if (i == 15) begin
        @(negedge clk);
        check(use_b ? "b_latency_pre" : "a_latency_pre", 32'(use_b ? rv_b : rv_a), 32'd0);
      end
    end
    step();
    cv_a = 1'b0; op_a = 1'b0; start_a = 1'b0;
    cv_b = 1'b0; op_b = 1'b0;
    @(negedge clk);
    check(use_b ? "b_latency" : "a_latency", 32'(use_b ? rv_b : rv_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #23;
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(rv_a), 32'd0);
    check("rst_hit", 32'(hit_a), 32'd0);
    check("rst_dropped", 32'(dropped_a), 32'd0);

    // 13 of 16 inside, start pulsed mid-batch must not reset counts
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    @(negedge clk);
    check("busy_run", 32'(busy_a), 32'd1);
    exp_a.push_back(5'd13);
    send_batch(1'b0, 16'hFFF8, 1'b1);

    // Hold ready low: output held, start in DONE ignored
    for (int i = 0; i < 10; i++) begin
      step();
      start_a = (i == 3);
      @(negedge clk);
      check("hold_valid", 32'(rv_a), 32'd1);
      check("hold_hit", 32'(hit_a), 32'd13);
      check("hold_busy", 32'(busy_a), 32'd0);
    end
    step();
    start_a = 1'b0;
    ready_a = 1'b1;
    step();
    ready_a = 1'b0;
    @(negedge clk);
    check("accept_valid_drop", 32'(rv_a), 32'd0);
    step();
    step();
    @(negedge clk);
    check("idle_after_accept", 32'(busy_a), 32'd0);
    check("no_drop_yet", 32'(dropped_a), 32'd0);

    // All outside then all inside, ready held high
    ready_a = 1'b1;
    step(); start_a = 1'b1; step(); start_a = 1'b0;
    exp_a.push_back(5'd0);
    send_batch(1'b0, 16'h0000, 1'b0);
    step(); step();
    step(); start_a = 1'b1; step(); start_a = 1'b0;
    exp_a.push_back(5'd16);
    send_batch(1'b0, 16'hFFFF, 1'b0);
    step(); step();
    @(negedge clk);
    check("idle_after_all_in", 32'(busy_a), 32'd0);

    // coord_valid while IDLE
    step(); cv_a = 1'b1; op_a = 1'b1;
    step(); cv_a = 1'b0; op_a = 1'b0;
    @(negedge clk);
    check("idle_dropped", 32'(dropped_a), 32'd1);
    check("idle_hit_kept", 32'(hit_a), 32'd16);
    check("idle_valid", 32'(rv_a), 32'd0);

    // Asynchronous reset mid-batch
    step(); start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); cv_a = 1'b1; op_a = 1'b1;
    end
    step(); cv_a = 1'b0; op_a = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy_a), 32'd0);
    check("async_valid", 32'(rv_a), 32'd0);
    check("async_hit", 32'(hit_a), 32'd0);
    check("async_pi", 32'(pi_a), 32'd0);
    check("async_dropped", 32'(dropped_a), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    check("post_reset_idle", 32'(busy_a), 32'd0);
    check("post_reset_valid", 32'(rv_a), 32'd0);

    // AUTO_RESTART: back-to-back batches 13 then 7 with ready tied high
    step(); start_b = 1'b1; step(); start_b = 1'b0;
    exp_b.push_back(5'd13);
    send_batch(1'b1, 16'hFFF8, 1'b0);
    check("b_done_busy", 32'(busy_b), 32'd0);
    step();
    @(negedge clk);
    check("b_rerun_busy", 32'(busy_b), 32'd1);
    check("b_rerun_valid", 32'(rv_b), 32'd0);
    // Last step before the next burst is inside send_batch; state is RUN here.
    exp_b.push_back(5'd7);
    send_batch(1'b1, 16'h007F, 1'b0);
    step();
    @(negedge clk);
    check("b_third_busy", 32'(busy_b), 32'd1);
    check("b_dropped", 32'(dropped_b), 32'd0);

    step(); step();
    check("a_queue_empty", 32'(exp_a.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
